// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage
//   Writeback stage sitting directly after the execute stage. Each handshake
//   accepts one EX result:
//     kind 00 : scalar ALU result, written to the scalar RF on the next cycle
//     kind 01 : vector ALU result, buffered then written one lane per grant
//     kind 10 : vector-vector sum, buffered then written one lane per grant
//     kind 11 : dropped (consumed without any write)
//   While a vector burst is running the stage drops ex_ready to stall EX.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   ex_valid / ex_ready    EX handshake; ex_ready = IDLE and out of reset
//   ex_kind, ex_rd         result kind and destination register
//   ex_res_e               scalar result
//   ex_res_ve, ex_res_sum  vector ALU / vector sum results (LANES*LANE_W)
//   sreg_we/waddr/wdata    scalar RF write port (single-cycle pulse)
//   vreg_we/waddr/lane/wdata, vreg_gnt
//                          lane-wide vector RF write port with grant
//   busy                   burst in progress
//   wb_done                one-cycle pulse after the last lane is granted
// ---------------------------------------------------------------------------
module wb_stage #(
    parameter int SCALAR_W = 21,
    parameter int LANE_W   = 24,
    parameter int LANES    = 8,
    parameter int REG_AW   = 5,
    localparam int LIDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ex_valid,
    output logic                    ex_ready,
    input  logic [1:0]              ex_kind,
    input  logic [REG_AW-1:0]       ex_rd,
    input  logic [SCALAR_W-1:0]     ex_res_e,
    input  logic [LANES*LANE_W-1:0] ex_res_ve,
    input  logic [LANES*LANE_W-1:0] ex_res_sum,
    output logic                    sreg_we,
    output logic [REG_AW-1:0]       sreg_waddr,
    output logic [SCALAR_W-1:0]     sreg_wdata,
    output logic                    vreg_we,
    input  logic                    vreg_gnt,
    output logic [REG_AW-1:0]       vreg_waddr,
    output logic [LIDX_W-1:0]       vreg_lane,
    output logic [LANE_W-1:0]       vreg_wdata,
    output logic                    busy,
    output logic                    wb_done
);

    localparam int VEC_W = LANES * LANE_W;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t              state;
    logic [LIDX_W-1:0]   cnt;
    logic [VEC_W-1:0]    vbuf;
    logic [REG_AW-1:0]   rd;

    // ex_ready is gated by rst_n so it is low throughout reset and rises on
    // the first cycle after release without waiting for a clock edge.
    assign ex_ready   = (state == IDLE) & rst_n;
    assign busy       = (state != IDLE);
    assign vreg_we    = (state == BURST);
    assign vreg_waddr = rd;
    assign vreg_lane  = cnt;
    assign vreg_wdata = vbuf[int'(cnt)*LANE_W +: LANE_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            vbuf       <= '0;
            rd         <= '0;
            sreg_we    <= 1'b0;
            sreg_waddr <= '0;
            sreg_wdata <= '0;
            wb_done    <= 1'b0;
        end else begin
            sreg_we <= 1'b0;
            wb_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        case (ex_kind)
                            2'b00: begin
                                sreg_we    <= 1'b1;
                                sreg_waddr <= ex_rd;
                                sreg_wdata <= ex_res_e;
                            end
                            2'b01: begin
                                vbuf  <= ex_res_ve;
                                rd    <= ex_rd;
                                cnt   <= '0;
                                state <= BURST;
                            end
                            2'b10: begin
                                vbuf  <= ex_res_sum;
                                rd    <= ex_rd;
                                cnt   <= '0;
                                state <= BURST;
                            end
                            default: ;
                        endcase
                    end
                end
                BURST: begin
                    // Without a grant nothing moves, so every vreg_* output holds.
                    if (vreg_gnt) begin
                        if (cnt == LIDX_W'(LANES - 1)) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            wb_done <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
